matmul_result_collector: RTL

//  Upstream feeder of the matmul golden comparator. On each test it reads the DUT result

---
 rtl/matmul_result_collector.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/matmul_result_collector.sv
// Purpose: reads an N x M result matrix out of a selected scratchpad over a req/ack bus and pulses start_cmp when the matrix is complete.
// Latency: collect_start in cycle 0, one read per REQ cycle with zero-wait acks, start_cmp in cycle N*M+1.
// Backpressure: rd_req is held with a stable rd_addr until rd_ack; a read with no ack for TIMEOUT cycles aborts with timeout_err.
module matmul_result_collector #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUS_WIDTH    = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int SP_BASE_ADDR = 'h0100,
    parameter int SP_STRIDE    = 'h0010,
    parameter int TIMEOUT      = 255,
    localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    localparam int DIM_W       = $clog2(MAX_DIM) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 collect_start,
    input  logic [DIM_W-1:0]                     n_dim,
    input  logic [DIM_W-1:0]                     m_dim,
    input  logic [1:0]                           sp_sel,
    output logic                                 rd_req,
    output logic [ADDR_WIDTH-1:0]                rd_addr,
    input  logic                                 rd_ack,
    input  logic [BUS_WIDTH-1:0]                 rd_data,
    output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] mat_res_actual,
    output logic                                 start_cmp,
    output logic                                 busy,
    output logic                                 dim_err,
    output logic                                 timeout_err
);

    localparam int ELEMS = MAX_DIM * MAX_DIM;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIM_W-1:0]   n_lat;
    logic [DIM_W-1:0]   m_lat;
    logic [1:0]         sp_lat;
    logic [DIM_W-1:0]   i_idx;
    logic [DIM_W-1:0]   j_idx;
    logic [TMR_W-1:0]   timer;
    logic               dims_ok;
    logic               last_elem;
    logic               row_end;
    logic               timer_exp;
    logic               start_acc;
    int                 elem_idx;
    logic [ADDR_WIDTH-1:0] addr_calc;

    // Decode of the request handshake and dimension legality
    always_comb begin
        dims_ok   = (n_dim != '0) && (m_dim != '0) &&
                    (n_dim <= DIM_W'(MAX_DIM)) && (m_dim <= DIM_W'(MAX_DIM));
        row_end   = (j_idx == m_lat - DIM_W'(1));
        last_elem = row_end && (i_idx == n_lat - DIM_W'(1));
        timer_exp = (timer == TMR_W'(TIMEOUT - 1));
        start_acc = (state == IDLE) && collect_start;
        elem_idx  = int'(i_idx) * MAX_DIM + int'(j_idx);
        addr_calc = ADDR_WIDTH'(SP_BASE_ADDR)
                  + ADDR_WIDTH'(sp_lat) * ADDR_WIDTH'(SP_STRIDE)
                  + ADDR_WIDTH'(i_idx) * ADDR_WIDTH'(MAX_DIM)
                  + ADDR_WIDTH'(j_idx);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: illegal dims keep us in IDLE, a stalled read falls back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_acc && dims_ok) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (rd_ack) begin
                    if (last_elem) begin
                        state_nxt = DONE;
                    end
                end else if (timer_exp) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded straight from the state register
    always_comb begin
        rd_req    = (state == REQ);
        start_cmp = (state == DONE);
        busy      = (state != IDLE);
        rd_addr   = (state == REQ) ? addr_calc : '0;
    end

    // Command latch, element walk, ack timer, error flags and matrix capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat          <= '0;
            m_lat          <= '0;
            sp_lat         <= '0;
            i_idx          <= '0;
            j_idx          <= '0;
            timer          <= '0;
            dim_err        <= 1'b0;
            timeout_err    <= 1'b0;
            mat_res_actual <= '0;
        end else if (start_acc) begin
            n_lat          <= n_dim;
            m_lat          <= m_dim;
            sp_lat         <= sp_sel;
            i_idx          <= '0;
            j_idx          <= '0;
            timer          <= '0;
            dim_err        <= !dims_ok;
            timeout_err    <= 1'b0;
            mat_res_actual <= '0;
        end else if (state == REQ) begin
            if (rd_ack) begin
                timer <= '0;
                for (int k = 0; k < ELEMS; k++) begin
                    if (k == elem_idx) begin
                        mat_res_actual[k*BUS_WIDTH +: BUS_WIDTH] <= rd_data;
                    end
                end
                if (!last_elem) begin
                    if (row_end) begin
                        j_idx <= '0;
                        i_idx <= i_idx + DIM_W'(1);
                    end else begin
                        j_idx <= j_idx + DIM_W'(1);
                    end
                end
            end else if (timer_exp) begin
                timer       <= '0;
                timeout_err <= 1'b1;
            end else begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

endmodule
